// File: rtl/reverb_delay_line.sv
// reverb_delay_line: feedback delay line for the reverb voice path.
// A circular buffer of 2**ADDR_W samples is read (decay_length << octave)
// samples behind the write pointer; the tap is the wet output and is fed
// back, scaled by fb_gain (Q0.FB_W), into the saturating write value.
// The buffer is zeroed by a CLEAR sweep after every reset.
// Optional feature macro: REVERB_WET_MIX_EN (adds a dry/wet mix input).
module reverb_delay_line #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 11,
  parameter int FB_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  output logic                     ready,
  input  logic signed [DATA_W-1:0] din,
  input  logic [LEN_W-1:0]         decay_length,
  input  logic [1:0]               octave,
  input  logic [FB_W-1:0]          fb_gain,
`ifdef REVERB_WET_MIX_EN
  input  logic [7:0]               mix,
`endif
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     overrun,
  output logic                     busy_clear
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LW    = LEN_W + 3;
  localparam int CW    = ((LW > ADDR_W) ? LW : ADDR_W) + 1;
  localparam int SW    = DATA_W + FB_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (DATA_W-1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (DATA_W-1));

  typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, WRITE} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_W-1:0]          wr_ptr, clr_ptr;
  logic signed [DATA_W-1:0]   ram [DEPTH];
  logic                       ram_we;
  logic [ADDR_W-1:0]          ram_waddr;
  logic signed [DATA_W-1:0]   ram_wdata;

  logic signed [DATA_W-1:0]   din_p0;
  logic [FB_W-1:0]            gain_p0;
  logic [ADDR_W-1:0]          rd_addr_p0;
  logic signed [DATA_W-1:0]   tap_p1;
  logic signed [SW-1:0]       acc_p1;
  logic signed [DATA_W-1:0]   wet_p1;
  logic signed [DATA_W-1:0]   sum_p2;

`ifdef REVERB_WET_MIX_EN
  localparam int MW = DATA_W + 10;
  logic [7:0]                 mix_p0;
  logic signed [9:0]          mix_s, dry_s;
`endif

  // Delay length: base shifted by octave, kept within [4, DEPTH-1] so the
  // read always trails the write and never aliases it.
  function automatic logic [ADDR_W-1:0] clamp_len(input logic [LEN_W-1:0] base,
                                                  input logic [1:0] oct);
    logic [CW-1:0] raw;
    raw = CW'(base) << oct;
    if (raw < CW'(4))
      return ADDR_W'(4);
    else if (raw > CW'(DEPTH-1))
      return ADDR_W'(DEPTH-1);
    else
      return raw[ADDR_W-1:0];
  endfunction

  // Clip the widened accumulation back to the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  // State register, pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      dout_valid <= (state == CALC);
      if (state == CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
      if (state == WRITE) wr_ptr  <= wr_ptr + ADDR_W'(1);
      if (state == CALC)  dout    <= wet_p1;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt  = state;
    ready      = (state == IDLE);
    busy_clear = (state == CLEAR);
    overrun    = sample_valid && (state != IDLE) && !reset;
    case (state)
      CLEAR:   if (clr_ptr == ADDR_W'(DEPTH-1)) state_nxt = IDLE;
      IDLE:    if (sample_valid) state_nxt = READ;
      READ:    state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // RAM write port: zero sweep while clearing, feedback sum in WRITE.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_wdata = sum_p2;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = '0;
    end else if (state == WRITE) begin
      ram_we    = 1'b1;
    end
  end

  // Stage p1 -> p2 arithmetic: feedback accumulate and wet output select.
  always_comb begin
    acc_p1 = ((SW'(din_p0) <<< FB_W)
             + SW'(tap_p1) * SW'($signed({1'b0, gain_p0}))) >>> FB_W;
`ifdef REVERB_WET_MIX_EN
    mix_s  = $signed({2'b00, mix_p0});
    dry_s  = 10'sd256 - mix_s;
    wet_p1 = DATA_W'((MW'(din_p0) * MW'(dry_s) + MW'(tap_p1) * MW'(mix_s)) >>> 8);
`else
    wet_p1 = tap_p1;
`endif
  end

  // Stage p0: capture sample, gain and read address on acceptance.
  // Stage p2: register the saturated write value during CALC.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_valid) begin
      din_p0     <= din;
      gain_p0    <= fb_gain;
      rd_addr_p0 <= wr_ptr - clamp_len(decay_length, octave);
`ifdef REVERB_WET_MIX_EN
      mix_p0     <= mix;
`endif
    end
    if (state == CALC) sum_p2 <= sat(acc_p1);
  end

  // Stage p1: buffer storage with synchronous read of the delayed tap.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (state == READ) tap_p1 <= ram[rd_addr_p0];
  end

endmodule
